// File: rtl/leitor_amostras.sv
// Playback sample reader: fetches one sample ahead from external memory at the
// address generator's current address, plays it at a fixed tick rate, and emits PWM audio.
module leitor_amostras #(
    parameter int ADDR_WIDTH = 22,
    parameter int DATA_WIDTH = 8,
    parameter int TICK_DIV   = 1134
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  play,
    input  logic [ADDR_WIDTH-1:0] endereco,
    output logic                  avanca,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_ack,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic [DATA_WIDTH-1:0] amostra,
    output logic                  audio_pwm,
    output logic                  underrun
);

    localparam int TICK_W = $clog2(TICK_DIV);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        READY = 2'd2
    } state_t;

    state_t                r_state;
    logic [TICK_W-1:0]     r_tick_cnt;
    logic [DATA_WIDTH-1:0] r_pwm_cnt;
    logic [DATA_WIDTH-1:0] r_buf;
    logic [DATA_WIDTH-1:0] r_amostra;
    logic [ADDR_WIDTH-1:0] r_req_addr;
    logic [ADDR_WIDTH-1:0] r_buf_addr;
    logic                  r_avanca;
    logic                  r_mem_req;
    logic                  r_audio_pwm;
    logic                  r_underrun;

    logic                  w_tick;
    logic                  w_mismatch;

    // Gating with play keeps a stale terminal count from firing on the cycle play drops.
    assign w_tick     = play && (r_tick_cnt == TICK_LAST);
    assign w_mismatch = (endereco != r_buf_addr);

    assign avanca    = r_avanca;
    assign mem_req   = r_mem_req;
    assign mem_addr  = r_req_addr;
    assign amostra   = r_amostra;
    assign audio_pwm = r_audio_pwm;
    assign underrun  = r_underrun;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_tick_cnt <= '0;
        end else if (!play || r_tick_cnt == TICK_LAST) begin
            r_tick_cnt <= '0;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pwm_cnt   <= '0;
            r_audio_pwm <= 1'b0;
        end else begin
            r_pwm_cnt   <= r_pwm_cnt + 1'b1;
            r_audio_pwm <= play && (r_pwm_cnt < r_amostra);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_req_addr <= '0;
            r_buf_addr <= '0;
            r_buf      <= '0;
            r_amostra  <= '0;
            r_avanca   <= 1'b0;
            r_mem_req  <= 1'b0;
            r_underrun <= 1'b0;
        end else begin
            r_avanca   <= 1'b0;
            r_underrun <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (play) begin
                        r_req_addr <= endereco;
                        r_mem_req  <= 1'b1;
                        r_state    <= FETCH;
                    end
                end
                FETCH: begin
                    // A tick here finds nothing to play; the handshake always runs to completion.
                    r_underrun <= w_tick;
                    if (mem_ack) begin
                        r_buf      <= mem_data;
                        r_buf_addr <= r_req_addr;
                        r_mem_req  <= 1'b0;
                        r_state    <= play ? READY : IDLE;
                    end
                end
                READY: begin
                    if (!play) begin
                        r_state <= IDLE;
                    end else if (w_mismatch) begin
                        r_req_addr <= endereco;
                        r_mem_req  <= 1'b1;
                        r_underrun <= w_tick;
                        r_state    <= FETCH;
                    end else if (w_tick) begin
                        // Prefetch the address the generator will hold after this advance.
                        r_amostra  <= r_buf;
                        r_avanca   <= 1'b1;
                        r_req_addr <= endereco + ADDR_WIDTH'(1);
                        r_mem_req  <= 1'b1;
                        r_state    <= FETCH;
                    end
                end
                default: begin
                    r_mem_req <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_leitor_amostras.sv
// Bench for leitor_amostras: memory returns addr[7:0] after ack_delay clocks and the
// address generator increments endereco on avanca; checks directed scenarios plus random play.
module tb_leitor_amostras;

    localparam int AW = 22;
    localparam int DW = 8;
    localparam int TD = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          play;
    logic [AW-1:0] endereco;
    logic          avanca;
    logic          mem_req;
    logic [AW-1:0] mem_addr;
    logic          mem_ack;
    logic [DW-1:0] mem_data;
    logic [DW-1:0] amostra;
    logic          audio_pwm;
    logic          underrun;

    int n_vec = 0;
    int n_err = 0;
    int ack_delay = 2;
    int mem_cnt = 0;
    bit inject_ack = 1'b0;

    logic [DW-1:0] prev_amostra;
    logic [AW-1:0] prev_mem_addr;
    logic          prev_req;

    always #5 clk = ~clk;

    leitor_amostras #(
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .TICK_DIV  (TD)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .play     (play),
        .endereco (endereco),
        .avanca   (avanca),
        .mem_req  (mem_req),
        .mem_addr (mem_addr),
        .mem_ack  (mem_ack),
        .mem_data (mem_data),
        .amostra  (amostra),
        .audio_pwm(audio_pwm),
        .underrun (underrun)
    );

    // Environment reacts to the outputs seen at the current sample point, then one clock passes.
    task automatic step();
        if (avanca === 1'b1) endereco = endereco + 22'd1;
        if (inject_ack) begin
            mem_ack    = 1'b1;
            mem_data   = 8'hAA;
            inject_ack = 1'b0;
        end else if (mem_ack) begin
            mem_ack = 1'b0;
            mem_cnt = 0;
        end else if (mem_req === 1'b1) begin
            mem_cnt++;
            if (mem_cnt >= ack_delay) begin
                mem_ack  = 1'b1;
                mem_data = mem_addr[7:0];
            end
        end else begin
            mem_cnt = 0;
        end
        prev_amostra  = amostra;
        prev_mem_addr = mem_addr;
        prev_req      = mem_req;
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset(input int delay);
        reset      = 1'b1;
        play       = 1'b0;
        mem_ack    = 1'b0;
        mem_cnt    = 0;
        inject_ack = 1'b0;
        ack_delay  = delay;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        bit found;
        reset = 1'b1; play = 1'b0; endereco = '0; mem_ack = 1'b0; mem_data = '0;
        step();
        step();
        n_vec++;
        if ({avanca, mem_req, audio_pwm, underrun} !== 4'b0)
            begin n_err++; $display("FAIL reset_flags got %b want 0000", {avanca, mem_req, audio_pwm, underrun}); end
        n_vec++;
        if (mem_addr !== '0 || amostra !== '0)
            begin n_err++; $display("FAIL reset_regs got addr=%0d amostra=%0d want 0 0", mem_addr, amostra); end
        reset = 1'b0; endereco = 22'd37; play = 1'b1; found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (avanca === 1'b1) found = 1'b1;
        end
        n_vec++;
        if (!found) begin n_err++; $display("FAIL reset_first_avanca got timeout want avanca"); end
        n_vec++;
        if (amostra !== 8'd37) begin n_err++; $display("FAIL reset_first_sample got %0d want 37", amostra); end
        n_vec++;
        if (mem_req !== 1'b1 || mem_addr !== 22'd38)
            begin n_err++; $display("FAIL reset_prefetch got req=%b addr=%0d want 1 38", mem_req, mem_addr); end
        reset = 1'b1;
        #1;
        n_vec++;
        if ({mem_req, audio_pwm, avanca} !== 3'b0 || amostra !== '0)
            begin n_err++; $display("FAIL reset_async got req=%b pwm=%b av=%b amostra=%0d want 0", mem_req, audio_pwm, avanca, amostra); end
        play = 1'b0;
        step();
        step();
        reset = 1'b0; mem_ack = 1'b0; mem_cnt = 0;
        step();
        inject_ack = 1'b1;
        step();
        step();
        n_vec++;
        if (mem_req !== 1'b0 || amostra !== '0 || avanca !== 1'b0)
            begin n_err++; $display("FAIL reset_late_ack got req=%b amostra=%0d av=%b want 0 0 0", mem_req, amostra, avanca); end
        play = 1'b1; found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            step();
            if (avanca === 1'b1) found = 1'b1;
        end
        n_vec++;
        if (!found || amostra !== 8'd37)
            begin n_err++; $display("FAIL reset_resume got found=%b amostra=%0d want 1 37", found, amostra); end
    endtask

    task automatic test_steady();
        do_reset(2);
        endereco = 22'd100; play = 1'b1;
        for (int k = 1; k <= 32; k++) begin
            step();
            n_vec++;
            if (k % TD == 0) begin
                if (avanca !== 1'b1 || underrun !== 1'b0 || amostra !== 8'(100 + k / TD - 1))
                    begin n_err++; $display("FAIL steady_tick k=%0d got av=%b ur=%b amostra=%0d want 1 0 %0d", k, avanca, underrun, amostra, 100 + k / TD - 1); end
            end else if (avanca !== 1'b0 || underrun !== 1'b0) begin
                n_err++; $display("FAIL steady_quiet k=%0d got av=%b ur=%b want 0 0", k, avanca, underrun);
            end
        end
    endtask

    task automatic test_skip();
        logic [DW-1:0] exp_s;
        do_reset(2);
        endereco = 22'd100; play = 1'b1;
        for (int k = 1; k <= 48; k++) begin
            step();
            n_vec++;
            if (k % TD == 0) begin
                exp_s = (k <= 40) ? 8'(100 + k / TD - 1) : 8'h51;
                if (avanca !== 1'b1 || underrun !== 1'b0 || amostra !== exp_s)
                    begin n_err++; $display("FAIL skip_tick k=%0d got av=%b ur=%b amostra=%0h want 1 0 %0h", k, avanca, underrun, amostra, exp_s); end
            end else if (avanca !== 1'b0 || underrun !== 1'b0) begin
                n_err++; $display("FAIL skip_quiet k=%0d got av=%b ur=%b want 0 0", k, avanca, underrun);
            end
            if (k == 45) begin
                n_vec++;
                if (mem_req !== 1'b1 || mem_addr !== 22'd1105)
                    begin n_err++; $display("FAIL skip_refetch got req=%b addr=%0d want 1 1105", mem_req, mem_addr); end
            end
            if (k == 44) endereco = 22'd1105;
        end
    endtask

    task automatic test_slow_mem();
        do_reset(10);
        endereco = 22'd200; play = 1'b1;
        for (int k = 1; k <= 64; k++) begin
            step();
            if (prev_req === 1'b1 && mem_req === 1'b1) begin
                n_vec++;
                if (mem_addr !== prev_mem_addr)
                    begin n_err++; $display("FAIL slow_addr_stable k=%0d got %0d want %0d", k, mem_addr, prev_mem_addr); end
            end
            n_vec++;
            if (k % TD == 0 && (k / TD) % 2 == 1) begin
                if (underrun !== 1'b1 || avanca !== 1'b0 || amostra !== prev_amostra)
                    begin n_err++; $display("FAIL slow_underrun k=%0d got ur=%b av=%b amostra=%0d want 1 0 %0d", k, underrun, avanca, amostra, prev_amostra); end
            end else if (k % TD == 0) begin
                if (avanca !== 1'b1 || underrun !== 1'b0 || amostra !== 8'(200 + k / 16 - 1))
                    begin n_err++; $display("FAIL slow_play k=%0d got av=%b ur=%b amostra=%0d want 1 0 %0d", k, avanca, underrun, amostra, 200 + k / 16 - 1); end
            end else if (avanca !== 1'b0 || underrun !== 1'b0) begin
                n_err++; $display("FAIL slow_quiet k=%0d got av=%b ur=%b want 0 0", k, avanca, underrun);
            end
        end
    endtask

    task automatic test_pause();
        bit acked;
        do_reset(4);
        endereco = 22'd300; play = 1'b1;
        for (int k = 1; k <= 8; k++) step();
        n_vec++;
        if (avanca !== 1'b1 || amostra !== 8'(300))
            begin n_err++; $display("FAIL pause_first got av=%b amostra=%0d want 1 44", avanca, amostra); end
        play = 1'b0; acked = 1'b0;
        for (int i = 0; i < 20 && !acked; i++) begin
            step();
            n_vec++;
            if (mem_ack === 1'b1) begin
                acked = 1'b1;
                if (mem_req !== 1'b0) begin n_err++; $display("FAIL pause_req_drop got %b want 0", mem_req); end
            end else if (mem_req !== 1'b1 || mem_addr !== 22'd301) begin
                n_err++; $display("FAIL pause_handshake got req=%b addr=%0d want 1 301", mem_req, mem_addr);
            end
        end
        n_vec++;
        if (!acked) begin n_err++; $display("FAIL pause_ack got timeout want ack"); end
        for (int i = 0; i < 30; i++) begin
            step();
            n_vec++;
            if ({avanca, underrun, audio_pwm, mem_req} !== 4'b0)
                begin n_err++; $display("FAIL pause_idle got av/ur/pwm/req=%b want 0000", {avanca, underrun, audio_pwm, mem_req}); end
        end
        n_vec++;
        if (endereco !== 22'd301) begin n_err++; $display("FAIL pause_addr got %0d want 301", endereco); end
        play = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            step();
            if (k == 1) begin
                n_vec++;
                if (mem_req !== 1'b1 || mem_addr !== 22'd301)
                    begin n_err++; $display("FAIL pause_resume_req got req=%b addr=%0d want 1 301", mem_req, mem_addr); end
            end
            n_vec++;
            if (k < 8 && avanca !== 1'b0) begin
                n_err++; $display("FAIL pause_resume_early k=%0d got av=%b want 0", k, avanca);
            end else if (k == 8 && (avanca !== 1'b1 || amostra !== 8'(301))) begin
                n_err++; $display("FAIL pause_resume_play got av=%b amostra=%0d want 1 45", avanca, amostra);
            end
        end
    endtask

    task automatic test_wrap();
        do_reset(2);
        endereco = 22'h3FFFFF; play = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step();
            if (k == 8) begin
                n_vec++;
                if (avanca !== 1'b1 || amostra !== 8'hFF || mem_req !== 1'b1 || mem_addr !== '0)
                    begin n_err++; $display("FAIL wrap_prefetch got av=%b amostra=%0h addr=%0h want 1 ff 0", avanca, amostra, mem_addr); end
            end
            if (k == 16) begin
                n_vec++;
                if (avanca !== 1'b1 || amostra !== 8'h00)
                    begin n_err++; $display("FAIL wrap_play got av=%b amostra=%0h want 1 0", avanca, amostra); end
            end
        end
    endtask

    task automatic test_pwm();
        int a;
        int highs;
        bit found;
        for (int t = 0; t < 3; t++) begin
            a = (t == 0) ? 64 : (t == 1) ? 256 : int'($urandom_range(1, 4095));
            do_reset(2);
            endereco = 22'(a); play = 1'b1; found = 1'b0;
            for (int i = 0; i < 20 && !found; i++) begin
                step();
                if (avanca === 1'b1) found = 1'b1;
            end
            n_vec++;
            if (!found || amostra !== 8'(a))
                begin n_err++; $display("FAIL pwm_load got found=%b amostra=%0d want 1 %0d", found, amostra, a % 256); end
            ack_delay = 1000000;
            for (int i = 0; i < 4; i++) step();
            highs = 0;
            for (int i = 0; i < 256; i++) begin
                step();
                if (audio_pwm === 1'b1) highs++;
            end
            n_vec++;
            if (highs != a % 256) begin n_err++; $display("FAIL pwm_duty got %0d want %0d", highs, a % 256); end
            n_vec++;
            if (amostra !== 8'(a)) begin n_err++; $display("FAIL pwm_hold got %0d want %0d", amostra, a % 256); end
        end
    endtask

    task automatic test_random();
        int  k;
        int  r;
        bit  play_prev;
        bit  ev_exp;
        do_reset(2);
        endereco = 22'($urandom); play = 1'b1; k = 0;
        for (int i = 0; i < 800; i++) begin
            play_prev = play;
            step();
            if (play_prev) k++;
            ev_exp = play_prev && k > 0 && (k % TD == 0);
            n_vec++;
            if ((avanca | underrun) !== ev_exp || (avanca & underrun) !== 1'b0)
                begin n_err++; $display("FAIL rnd_tick i=%0d k=%0d got av=%b ur=%b want event=%b", i, k, avanca, underrun, ev_exp); end
            n_vec++;
            if (avanca === 1'b1 && amostra !== endereco[7:0])
                begin n_err++; $display("FAIL rnd_sample i=%0d got %0h want %0h", i, amostra, endereco[7:0]); end
            else if (avanca !== 1'b1 && amostra !== prev_amostra)
                begin n_err++; $display("FAIL rnd_hold i=%0d got %0h want %0h", i, amostra, prev_amostra); end
            if (prev_req === 1'b1 && mem_req === 1'b1) begin
                n_vec++;
                if (mem_addr !== prev_mem_addr)
                    begin n_err++; $display("FAIL rnd_addr_stable i=%0d got %0h want %0h", i, mem_addr, prev_mem_addr); end
            end
            if (!play_prev) begin
                n_vec++;
                if (audio_pwm !== 1'b0) begin n_err++; $display("FAIL rnd_pwm_off i=%0d got %b want 0", i, audio_pwm); end
            end
            r = int'($urandom_range(0, 99));
            if (play && r < 3 && avanca !== 1'b1) begin
                endereco = 22'($urandom);
            end else if (play && r == 3) begin
                play = 1'b0;
            end else if (!play && r < 10) begin
                play = 1'b1;
                k = 0;
            end
            if ($urandom_range(0, 39) == 0) ack_delay = int'($urandom_range(1, 12));
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; play = 1'b0; endereco = '0; mem_ack = 1'b0; mem_data = '0;
        prev_amostra = '0; prev_mem_addr = '0; prev_req = 1'b0;
        test_reset();
        test_steady();
        test_skip();
        test_slow_mem();
        test_pause();
        test_wrap();
        test_pwm();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
